inst_fetch: RTL

Instruction fetch stage feeding the single-cycle processor core's `Inst` input. Holds the program counter, issues word reads to a fixed-latency instruction memory, buffers returned words with their PCs in a small FIFO, and presents them downstream under a valid/ready handshake. A redirect input, driven by later branch/jump resolution, flushes buffered and in-flight words and restarts fetch at a new PC.

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch_fifo.sv | 50 +++++
 rtl/inst_fetch.sv | 88 ++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared widths, entry type and PC helpers for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetchEntry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries with a flush that empties it in one cycle.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  fetchEntry_t       pushData,
    output fetchEntry_t       headData,
    output logic [CNT_W-1:0]  count
);

    fetchEntry_t      mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wrPtr] <= pushData;
    end

    assign headData = mem[rdPtr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, credit-limited requests to a one-cycle memory,
// in-flight kill tracking on redirect, and a buffered valid/ready output.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int USE_W = CNT_W + 1;

    logic [PC_W-1:0]  pc;
    logic             running;
    logic             inflight;
    logic [PC_W-1:0]  inflightPc;
    logic             killBit;
    logic [CNT_W-1:0] fifoCount;
    logic [USE_W-1:0] slotsUsed;
    fetchEntry_t      head;
    fetchEntry_t      pushEntry;
    logic             pop;
    logic             push;

    assign pop = inst_valid && inst_ready;

    // Buffered plus in-flight words, less the one leaving now, must stay under DEPTH.
    assign slotsUsed = USE_W'(fifoCount) + USE_W'(inflight) - USE_W'(pop);
    assign imem_req  = running && !redirect && (slotsUsed < USE_W'(DEPTH));
    assign imem_addr = pc;

    assign push      = inflight && !killBit && !redirect;
    assign pushEntry = '{pc: inflightPc, inst: imem_rdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            running    <= 1'b0;
            inflight   <= 1'b0;
            inflightPc <= '0;
            killBit    <= 1'b0;
        end else begin
            running <= 1'b1;
            if (redirect) begin
                pc       <= alignPc(redirect_pc);
                inflight <= 1'b0;
                if (inflight) killBit <= 1'b1;
            end else if (imem_req) begin
                pc         <= pc + PC_STEP;
                inflight   <= 1'b1;
                inflightPc <= pc;
                killBit    <= 1'b0;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect),
        .pushData (pushEntry),
        .headData (head),
        .count    (fifoCount)
    );

    assign inst_valid = (fifoCount != '0);
    assign Inst       = inst_valid ? head.inst : '0;
    assign inst_pc    = inst_valid ? head.pc   : '0;

endmodule
